// File: rtl/cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfg_pkg : shared FSM state encoding and default sizing for the loader.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cfg_pkg;

    typedef enum logic [1:0] {
        S_ADDR   = 2'd0,
        S_DATA   = 2'd1,
        S_PAR    = 2'd2,
        S_COMMIT = 2'd3
    } cfg_state_t;

    localparam int c_num_frames = 10;
    localparam int c_frame_w    = 8;
    localparam int c_addr_w     = 4;

    function automatic int cfg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_frame_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfg_frame_reg : one configuration frame, async-reset register with enable. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cfg_frame_reg
    import cfg_pkg::*;
#(
    parameter int FRAME_W = c_frame_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [FRAME_W-1:0] i_d,
    output logic [FRAME_W-1:0] o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_we) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cfg_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfg_frame_loader : serial addressed-frame deserializer feeding NUM_FRAMES  |
// | fabric configuration registers. Optional trailing even parity: CFG_PARITY_EN|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cfg_frame_loader
    import cfg_pkg::*;
#(
    parameter int NUM_FRAMES = c_num_frames,
    parameter int FRAME_W    = c_frame_w,
    parameter int ADDR_W     = c_addr_w
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic                          cfg_data,
    output logic                          cfg_ready,
    output logic [NUM_FRAMES*FRAME_W-1:0] cfg_out,
    output logic                          frame_done,
    output logic                          frame_err
);

    localparam int c_cnt_w = $clog2(cfg_max(ADDR_W, FRAME_W) + 1);

    cfg_state_t           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [FRAME_W-1:0]   r_stage;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_commit;
    logic                 w_addr_ok;
    logic                 w_bad;
    logic [NUM_FRAMES-1:0] w_we;

    assign w_accept  = cfg_valid && r_ready;
    assign w_commit  = (r_state == S_COMMIT);
    // Widened by one bit so NUM_FRAMES == 2**ADDR_W compares correctly.
    assign w_addr_ok = ({1'b0, r_addr} < (ADDR_W + 1)'(NUM_FRAMES));

`ifdef CFG_PARITY_EN
    logic r_par;
    logic r_perr;
    assign w_bad = !w_addr_ok || r_perr;
`else
    assign w_bad = !w_addr_ok;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_stage <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef CFG_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_ADDR: begin
                    if (w_accept) begin
                        r_addr <= ADDR_W'({r_addr, cfg_data});
`ifdef CFG_PARITY_EN
                        r_par  <= r_par ^ cfg_data;
`endif
                        if (r_cnt == c_cnt_w'(ADDR_W - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_stage <= FRAME_W'({r_stage, cfg_data});
`ifdef CFG_PARITY_EN
                        r_par   <= r_par ^ cfg_data;
`endif
                        if (r_cnt == c_cnt_w'(FRAME_W - 1)) begin
                            r_cnt <= '0;
`ifdef CFG_PARITY_EN
                            r_state <= S_PAR;
`else
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
`ifdef CFG_PARITY_EN
                S_PAR: begin
                    if (w_accept) begin
                        // Even parity: address, data and parity bit XOR to zero.
                        r_perr  <= r_par ^ cfg_data;
                        r_state <= S_COMMIT;
                        r_ready <= 1'b0;
                    end
                end
`endif
                S_COMMIT: begin
                    r_done  <= !w_bad;
                    r_err   <= w_bad;
                    r_state <= S_ADDR;
                    r_ready <= 1'b1;
`ifdef CFG_PARITY_EN
                    r_par   <= 1'b0;
                    r_perr  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_ADDR;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frames
        assign w_we[f] = w_commit && !w_bad && (r_addr == ADDR_W'(f));

        cfg_frame_reg #(
            .FRAME_W (FRAME_W)
        ) u_frame (
            .clk  (clk),
            .rst  (rst),
            .i_we (w_we[f]),
            .i_d  (r_stage),
            .o_q  (cfg_out[f*FRAME_W +: FRAME_W])
        );
    end

    assign cfg_ready  = r_ready;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cfg_frame_loader : randomized bench for cfg_frame_loader against a      |
// | frame-array reference model. Honours CFG_PARITY_EN. Rev 1.0                |
// +----------------------------------------------------------------------------+
module tb_cfg_frame_loader;

    localparam int NF = 10;
    localparam int FW = 8;
    localparam int AW = 4;
`ifdef CFG_PARITY_EN
    localparam int c_flen = AW + FW + 1;
`else
    localparam int c_flen = AW + FW;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_data  = 1'b0;
    logic             cfg_ready;
    logic [NF*FW-1:0] cfg_out;
    logic             frame_done;
    logic             frame_err;

    cfg_frame_loader #(
        .NUM_FRAMES (NF),
        .FRAME_W    (FW),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cfg_out    (cfg_out),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_rdy_low = 0;
    int last_done_edge = 0, last_err_edge = 0, first_acc = 0;

    logic [FW-1:0] mem [NF];
    bit            q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done) begin
            n_done         <= n_done + 1;
            last_done_edge <= cyc;
        end
        if (frame_err) begin
            n_err         <= n_err + 1;
            last_err_edge <= cyc;
        end
        if (frame_done && frame_err) n_both <= n_both + 1;
        if (!cfg_ready) n_rdy_low <= n_rdy_low + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NF*FW-1:0] model_out();
        logic [NF*FW-1:0] r;
        for (int f = 0; f < NF; f++) r[f*FW +: FW] = mem[f];
        return r;
    endfunction

    task automatic push_bits(input int addr, input logic [FW-1:0] data, input bit flip);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        for (int i = AW - 1; i >= 0; i--) q.push_back(a[i]);
        for (int i = FW - 1; i >= 0; i--) q.push_back(data[i]);
`ifdef CFG_PARITY_EN
        q.push_back((^a) ^ (^data) ^ flip);
`endif
    endtask

    // Queues the frame's bits and applies its architectural effect to the model.
    task automatic queue_frame(input int addr, input logic [FW-1:0] data, input bit flip);
        bit bad;
        push_bits(addr, data, flip);
        bad = (addr >= NF);
`ifdef CFG_PARITY_EN
        bad = bad || flip;
`endif
        if (!bad) mem[addr] = data;
    endtask

    task automatic drive(input bit gaps, input int max_acc);
        int  guard = 0;
        int  popped = 0;
        bit  rdy;
        first_acc = -1;
        while (q.size() > 0 && guard < 4000 && (max_acc == 0 || popped < max_acc)) begin
            @(negedge clk);
            cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data  = q[0];
            rdy       = cfg_ready;
            if (cfg_valid && rdy && first_acc < 0) first_acc = cyc;
            @(posedge clk);
            if (cfg_valid && rdy) begin
                void'(q.pop_front());
                popped++;
            end
            guard++;
        end
        if (guard >= 4000) begin
            chk("drive_timeout", 128'(q.size()), 128'd0);
            q.delete();
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    int d0, e0, rl0;
    bit flip;

    initial begin
        for (int f = 0; f < NF; f++) mem[f] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out",   cfg_out,    model_out());
        chk("rst_done",  frame_done, 1'b0);
        chk("rst_err",   frame_err,  1'b0);
        chk("rst_ready", cfg_ready,  1'b1);

        // Single gapless frame: latency and ready timing.
        d0 = n_done; rl0 = n_rdy_low;
        queue_frame(3, 8'hA5, 1'b0);
        drive(1'b0, 0);
        chk("t1_out",      cfg_out,           model_out());
        chk("t1_slot3",    cfg_out[31:24],    8'hA5);
        chk("t1_latency",  last_done_edge - first_acc, c_flen + 1);
        chk("t1_rdy_low",  n_rdy_low - rl0,   1);
        chk("t1_done",     n_done - d0,       1);

        // Back-to-back frames including an overwrite.
        d0 = n_done; e0 = n_err;
        queue_frame(0, 8'h01, 1'b0);
        queue_frame(9, 8'hFF, 1'b0);
        queue_frame(0, 8'h7E, 1'b0);
        drive(1'b0, 0);
        chk("t2_out",   cfg_out,        model_out());
        chk("t2_slot0", cfg_out[7:0],   8'h7E);
        chk("t2_slot9", cfg_out[79:72], 8'hFF);
        chk("t2_done",  n_done - d0,    3);
        chk("t2_err",   n_err - e0,     0);

        // Out-of-range address, then alignment check.
        d0 = n_done; e0 = n_err;
        queue_frame(12, 8'h55, 1'b0);
        drive(1'b0, 0);
        chk("t3_out_bad", cfg_out,     model_out());
        chk("t3_err",     n_err - e0,  1);
        chk("t3_nodone",  n_done - d0, 0);
        queue_frame(2, 8'hC3, 1'b0);
        drive(1'b0, 0);
        chk("t3_out",   cfg_out,        model_out());
        chk("t3_slot2", cfg_out[23:16], 8'hC3);

        // Random valid gaps.
        d0 = n_done;
        queue_frame(5, 8'h3C, 1'b0);
        drive(1'b1, 0);
        chk("t4_out",  cfg_out,     model_out());
        chk("t4_done", n_done - d0, 1);

        // Reset after six accepted bits of a frame.
        d0 = n_done; e0 = n_err;
        push_bits(7, 8'hE7, 1'b0);
        drive(1'b0, 6);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        for (int f = 0; f < NF; f++) mem[f] = '0;
        #1;
        chk("t5_rst_out", cfg_out, model_out());
        @(negedge clk);
        rst = 1'b0;
        queue_frame(1, 8'h99, 1'b0);
        drive(1'b0, 0);
        chk("t5_out",   cfg_out,        model_out());
        chk("t5_slot1", cfg_out[15:8],  8'h99);
        chk("t5_done",  n_done - d0,    1);
        chk("t5_err",   n_err - e0,     0);

`ifdef CFG_PARITY_EN
        d0 = n_done; e0 = n_err;
        queue_frame(4, 8'h0F, 1'b0);
        queue_frame(4, 8'hF0, 1'b1);
        drive(1'b0, 0);
        chk("t6_out",   cfg_out,        model_out());
        chk("t6_slot4", cfg_out[39:32], 8'h0F);
        chk("t6_done",  n_done - d0,    1);
        chk("t6_err",   n_err - e0,     1);
        chk("t6_order", last_done_edge < last_err_edge, 1'b1);
`endif

        // Random batches of back-to-back frames.
        for (int b = 0; b < 5; b++) begin
            int exp_d, exp_e;
            d0 = n_done; e0 = n_err; exp_d = 0; exp_e = 0;
            for (int k = 0; k < 3; k++) begin
                int a;
                a = $urandom_range(0, (1 << AW) - 1);
`ifdef CFG_PARITY_EN
                flip = ($urandom_range(0, 3) == 0);
`else
                flip = 1'b0;
`endif
                if (a >= NF || flip) exp_e++; else exp_d++;
                queue_frame(a, 8'($urandom), flip);
            end
            drive(1'($urandom_range(0, 1)), 0);
            chk("rnd_out",  cfg_out,     model_out());
            chk("rnd_done", n_done - d0, exp_d);
            chk("rnd_err",  n_err - e0,  exp_e);
        end

        chk("pulse_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

Serial configuration loader for the FPGA fabric. It deserializes an addressed bitstream and demultiplexes each frame into one of NUM_FRAMES configuration registers. It sits at the write end of the configuration path. Its parallel `cfg_out` bus drives the select and data inputs of the fabric's routing muxes and logic cells, which read those bits back out.

## Interface
Parameters:
- NUM_FRAMES, 10, number of configuration frames (legal addresses 0..NUM_FRAMES-1)
- FRAME_W, 8, bits per frame
- ADDR_W, 4, frame-address header width; must satisfy 2**ADDR_W >= NUM_FRAMES

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- cfg_valid  input  1  serial bit valid
- cfg_data  input  1  serial bit
- cfg_ready  output  1  loader can accept a bit this cycle
- cfg_out  output  NUM_FRAMES*FRAME_W  frame f at cfg_out[f*FRAME_W +: FRAME_W]
- frame_done  output  1  one-cycle pulse: frame committed
- frame_err  output  1  one-cycle pulse: frame discarded (bad address, or parity with macro)

## Operation
- A bit is accepted when cfg_valid && cfg_ready. Nothing advances on cycles without an accept.
- Frame format, MSB first: ADDR_W address bits, then FRAME_W data bits, then 1 parity bit if CFG_PARITY_EN is defined.
- FSM states:
  - S_ADDR: shift the address in. After ADDR_W accepts, clear the bit counter and go to S_DATA.
  - S_DATA: shift data into a FRAME_W staging register. After FRAME_W accepts, go to S_PAR if the macro is defined, else S_COMMIT.
  - S_PAR: exists only with the macro. Accept 1 bit, compare it, go to S_COMMIT.
  - S_COMMIT: lasts exactly 1 cycle, with cfg_ready=0. On the exiting edge:
    - Valid frame: write the staging register to the addressed frame and pulse frame_done.
    - Address >= NUM_FRAMES (or parity fail): no write, pulse frame_err.
    - Then go to S_ADDR.
- An out-of-range address still consumes its full data (and parity) bits, so stream alignment is preserved.
- Frames not being written hold their value. Rewriting a frame overwrites it completely.
- cfg_ready = 1 in every state except S_COMMIT.

## Timing
- Reset (async assert): state S_ADDR, counters 0, staging register 0, cfg_out all 0, frame_done 0, frame_err 0, cfg_ready 1.
- Reset deasserting mid-frame: the partial frame is lost and the next bit is treated as address MSB.
- Bit counter width: clog2(max(ADDR_W, FRAME_W)+1). It wraps to 0 at each state change.
- Let edge E accept the final bit of a frame:
  - Cycle after E: S_COMMIT, cfg_ready=0.
  - Edge E+1: cfg_out updates; frame_done or frame_err rises.
  - Cycle after E+1: cfg_ready=1 again.
- Throughput: one frame per ADDR_W+FRAME_W(+1)+1 cycles with cfg_valid held high.
- cfg_valid asserted during S_COMMIT is ignored, and the source must hold the bit. A bit is consumed only on an accept.
- frame_done and frame_err are never high in the same cycle.

## Configuration
- CFG_PARITY_EN defined:
  - Each frame carries a trailing even-parity bit over the address and data bits.
  - On mismatch there is no write and frame_err pulses.
  - Frame length is ADDR_W+FRAME_W+1.
- CFG_PARITY_EN undefined:
  - S_PAR and the parity accumulator are not built.
  - Frame length is ADDR_W+FRAME_W.
  - frame_err only flags bad addresses.

## Structure
- Shared package cfg_pkg holds:
  - the FSM state enum (S_ADDR, S_DATA, S_PAR, S_COMMIT)
  - default NUM_FRAMES/FRAME_W/ADDR_W constants
- One sub-module, cfg_frame_reg. It is a FRAME_W-bit register with async reset to 0 and a write enable, instantiated NUM_FRAMES times. Write enable = commit && (addr == f) && !error.

## Test plan
- Reset, then address 4'd3 with data 8'hA5 and cfg_valid held high (no parity) -> cfg_out[31:24]=8'hA5, all other bits 0. frame_done pulses 13 cycles after the first accept. cfg_ready is low exactly 1 cycle.
- Frames to 0 (8'h01) and 9 (8'hFF), then again to 0 (8'h7E) -> cfg_out[7:0]=8'h7E, cfg_out[79:72]=8'hFF, with 3 frame_done pulses.
- Address 4'd12 with data 8'h55, then address 2 with 8'hC3 -> frame_err pulses once, with no cfg_out change from the first frame. Frame 2 = 8'hC3, confirming alignment is kept.
- Random cfg_valid gaps (50% duty) on frame 5 = 8'h3C -> same result as a gapless load. No bit is consumed while cfg_valid is low or during S_COMMIT.
- Assert rst after 6 accepted bits of a frame, release, then load frame 1 = 8'h99 -> cfg_out all 0 except frame 1 = 8'h99. No pulse from the aborted frame.
- With CFG_PARITY_EN: frame 4 = 8'h0F with a correct parity bit, then with a flipped parity bit and data 8'hF0 -> frame 4 = 8'h0F after both. Sequence is frame_done, then frame_err.
